// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches rising edges on sources 1..7 and
// dispatches them one at a time, lowest number first, holding further dispatches until EOI.
module irq_ctrl #(
  parameter logic [15:0] BASE         = 16'h0030,
  parameter logic [7:0]  DEFAULT_MASK = 8'h00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_src,
  input  logic [15:0] address,
  input  logic        we,
  input  logic [7:0]  data_o,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic        intr,
  output logic [2:0]  vect,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  mask_r;
  logic [7:0]  pending_r;
  logic [7:0]  prev_src_r;
  logic        intr_r;
  logic [2:0]  vect_r;

  logic        hit_mask_s;
  logic        hit_pend_s;
  logic        hit_eoi_s;
  logic        wr_mask_s;
  logic        wr_pend_s;
  logic        wr_eoi_s;
  logic [7:0]  rise_s;
  logic [7:0]  set_s;
  logic [7:0]  clr_s;
  logic        dispatch_s;
  logic [2:0]  dispatch_idx_s;
  logic [7:0]  dispatch_vec_s;

  // Index of the lowest set bit among 1..7; bit 0 never takes part.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  assign hit_mask_s = (address == BASE);
  assign hit_pend_s = (address == (BASE + 16'd1));
  assign hit_eoi_s  = (address == (BASE + 16'd2));
  assign wr_mask_s  = we & hit_mask_s;
  assign wr_pend_s  = we & hit_pend_s;
  assign wr_eoi_s   = we & hit_eoi_s;

  assign rise_s = irq_src & ~prev_src_r;
  assign set_s  = rise_s & mask_r & 8'hFE;
  assign clr_s  = (wr_pend_s ? data_o : 8'h00) | dispatch_vec_s;

  assign busy = (state_r == BUSY);
  assign intr = intr_r;
  assign vect = vect_r;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: dispatch leaves IDLE, only an EOI write leaves BUSY.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (dispatch_s) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (wr_eoi_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: which pending bit, if any, is dispatched this cycle.
  always_comb begin
    dispatch_s     = 1'b0;
    dispatch_idx_s = lowest_set(pending_r);
    dispatch_vec_s = 8'h00;
    case (state_r)
      IDLE: begin
        if (pending_r != 8'h00) begin
          dispatch_s     = 1'b1;
          dispatch_vec_s = 8'h01 << dispatch_idx_s;
        end else begin
          dispatch_s     = 1'b0;
        end
      end
      BUSY: begin
        dispatch_s = 1'b0;
      end
      default: begin
        dispatch_s = 1'b0;
      end
    endcase
  end

  // Edge history, mask, pending (set wins over clear) and dispatch outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_src_r <= 8'h00;
      mask_r     <= DEFAULT_MASK & 8'hFE;
      pending_r  <= 8'h00;
      intr_r     <= 1'b0;
      vect_r     <= 3'd0;
    end else begin
      prev_src_r <= irq_src;
      pending_r  <= (set_s | (pending_r & ~clr_s)) & 8'hFE;
      if (wr_mask_s) begin
        mask_r <= data_o & 8'hFE;
      end
      if (dispatch_s) begin
        vect_r <= dispatch_idx_s;
        intr_r <= ~intr_r;
      end
    end
  end

  // Register read mux.
  always_comb begin
    rd_data = 8'h00;
    rd_hit  = 1'b0;
    if (hit_mask_s) begin
      rd_data = mask_r;
      rd_hit  = 1'b1;
    end else if (hit_pend_s) begin
      rd_data = pending_r;
      rd_hit  = 1'b1;
    end else if (hit_eoi_s) begin
      rd_data = {busy, 4'b0000, vect_r};
      rd_hit  = 1'b1;
    end else begin
      rd_data = 8'h00;
      rd_hit  = 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'h0030;

  logic        clock;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic [15:0] address;
  logic        we;
  logic [7:0]  data_o;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        intr;
  logic [2:0]  vect;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  logic exp_intr = 1'b0;

  irq_ctrl #(.BASE(BASE), .DEFAULT_MASK(8'h00)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .address (address),
    .we      (we),
    .data_o  (data_o),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .intr    (intr),
    .vect    (vect),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a;
    data_o  = d;
    we      = 1'b1;
    @(negedge clock);
    we      = 1'b0;
    address = 16'h0000;
    data_o  = 8'h00;
  endtask

  task automatic set_addr(input logic [15:0] a);
    address = a;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    irq_src = 8'h00;
    address = 16'h0000;
    we      = 1'b0;
    data_o  = 8'h00;
    repeat (3) @(negedge clock);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", intr); end
    total++; if (vect !== 3'd0) begin bad++; $display("FAIL reset_vect: got %0d want 0", vect); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    set_addr(BASE);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_mask: got %h want 00", rd_data); end
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_pend: got %h want 00", rd_data); end
    @(negedge clock);
    reset_n = 1'b1;
    address = 16'h0000;
    @(negedge clock);
  endtask

  task automatic test_priority;
    bus_write(BASE, 8'h06);
    irq_src = 8'h06;
    @(negedge clock);
    irq_src = 8'h00;
    total++; if (intr !== exp_intr) begin bad++; $display("FAIL prio_early: got %b want %b", intr, exp_intr); end
    @(negedge clock);
    exp_intr = ~exp_intr;
    total++; if (intr !== exp_intr) begin bad++; $display("FAIL prio_intr1: got %b want %b", intr, exp_intr); end
    total++; if (vect !== 3'd1) begin bad++; $display("FAIL prio_vect1: got %0d want 1", vect); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy1: got %b want 1", busy); end
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h04) begin bad++; $display("FAIL prio_pend04: got %h want 04", rd_data); end
    bus_write(BASE + 16'd2, 8'h00);
    total++; if (busy !== 1'b0 || intr !== exp_intr) begin bad++; $display("FAIL prio_eoi: got busy=%b intr=%b want 0,%b", busy, intr, exp_intr); end
    @(negedge clock);
    exp_intr = ~exp_intr;
    total++; if (intr !== exp_intr) begin bad++; $display("FAIL prio_intr2: got %b want %b", intr, exp_intr); end
    total++; if (vect !== 3'd2) begin bad++; $display("FAIL prio_vect2: got %0d want 2", vect); end
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL prio_pend00: got %h want 00", rd_data); end
    bus_write(BASE + 16'd2, 8'h00);
  endtask

  task automatic test_mask_filter;
    logic changed;
    bus_write(BASE, 8'h02);
    irq_src = 8'h06;
    @(negedge clock);
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h02) begin bad++; $display("FAIL mask_pend: got %h want 02", rd_data); end
    irq_src = 8'h02;
    @(negedge clock);
    exp_intr = ~exp_intr;
    total++; if (intr !== exp_intr || vect !== 3'd1) begin bad++; $display("FAIL mask_disp: got intr=%b vect=%0d want %b,1", intr, vect, exp_intr); end
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mask_nobit2: got %h want 00", rd_data); end
    bus_write(BASE + 16'd2, 8'h00);
    changed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (intr !== exp_intr) changed = 1'b1;
    end
    total++; if (changed !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_once: got changed=%b busy=%b want 0,0", changed, busy); end
    irq_src = 8'h00;
    @(negedge clock);
  endtask

  task automatic test_busy_collect;
    irq_src = 8'h02;
    @(negedge clock);
    irq_src = 8'h00;
    @(negedge clock);
    exp_intr = ~exp_intr;
    total++; if (intr !== exp_intr || busy !== 1'b1) begin bad++; $display("FAIL busy_enter: got intr=%b busy=%b want %b,1", intr, busy, exp_intr); end
    bus_write(BASE, 8'h08);
    irq_src = 8'h08;
    @(negedge clock);
    irq_src = 8'h00;
    repeat (2) @(negedge clock);
    total++; if (intr !== exp_intr || busy !== 1'b1) begin bad++; $display("FAIL busy_hold: got intr=%b busy=%b want %b,1", intr, busy, exp_intr); end
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h08) begin bad++; $display("FAIL busy_pend: got %h want 08", rd_data); end
    bus_write(BASE + 16'd2, 8'h00);
    total++; if (intr !== exp_intr || busy !== 1'b0) begin bad++; $display("FAIL busy_eoi: got intr=%b busy=%b want %b,0", intr, busy, exp_intr); end
    @(negedge clock);
    exp_intr = ~exp_intr;
    total++; if (intr !== exp_intr || vect !== 3'd3) begin bad++; $display("FAIL busy_disp3: got intr=%b vect=%0d want %b,3", intr, vect, exp_intr); end
  endtask

  task automatic test_w1c_race;
    @(negedge clock);
    irq_src = 8'h08;
    address = BASE + 16'd1;
    data_o  = 8'h08;
    we      = 1'b1;
    @(negedge clock);
    we      = 1'b0;
    irq_src = 8'h00;
    data_o  = 8'h00;
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h08) begin bad++; $display("FAIL w1c_setwins: got %h want 08", rd_data); end
    bus_write(BASE + 16'd1, 8'h08);
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL w1c_clear: got %h want 00", rd_data); end
    bus_write(BASE + 16'd2, 8'h00);
    repeat (2) @(negedge clock);
    total++; if (intr !== exp_intr || busy !== 1'b0) begin bad++; $display("FAIL w1c_quiet: got intr=%b busy=%b want %b,0", intr, busy, exp_intr); end
  endtask

  task automatic test_reads;
    set_addr(BASE);
    total++; if (rd_hit !== 1'b1) begin bad++; $display("FAIL hit_base: got %b want 1", rd_hit); end
    set_addr(BASE + 16'd1);
    total++; if (rd_hit !== 1'b1) begin bad++; $display("FAIL hit_base1: got %b want 1", rd_hit); end
    set_addr(BASE + 16'd2);
    total++; if (rd_hit !== 1'b1 || rd_data !== 8'h03) begin bad++; $display("FAIL hit_base2: got hit=%b data=%h want 1,03", rd_hit, rd_data); end
    set_addr(BASE + 16'd3);
    total++; if (rd_hit !== 1'b0 || rd_data !== 8'h00) begin bad++; $display("FAIL hit_base3: got hit=%b data=%h want 0,00", rd_hit, rd_data); end
    bus_write(BASE, 8'hFF);
    bus_write(BASE + 16'd3, 8'h00);
    set_addr(BASE);
    total++; if (rd_data !== 8'hFE) begin bad++; $display("FAIL mask_ff: got %h want fe", rd_data); end
    irq_src = 8'h20;
    @(negedge clock);
    irq_src = 8'h00;
    @(negedge clock);
    exp_intr = ~exp_intr;
    set_addr(BASE + 16'd2);
    total++; if (rd_data !== 8'h85 || intr !== exp_intr) begin bad++; $display("FAIL status_85: got %h intr=%b want 85,%b", rd_data, intr, exp_intr); end
  endtask

  task automatic test_reset_mid;
    irq_src = 8'h08;
    @(negedge clock);
    irq_src = 8'h00;
    set_addr(BASE + 16'd1);
    total++; if (rd_data !== 8'h08) begin bad++; $display("FAIL mid_pend: got %h want 08", rd_data); end
    #5;
    reset_n = 1'b0;
    #1;
    total++; if (intr !== 1'b0 || vect !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_outs: got intr=%b vect=%0d busy=%b want 0,0,0", intr, vect, busy); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mid_pend0: got %h want 00", rd_data); end
    set_addr(BASE);
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mid_mask0: got %h want 00", rd_data); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (busy !== 1'b0 || intr !== 1'b0) begin bad++; $display("FAIL mid_after: got busy=%b intr=%b want 0,0", busy, intr); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask_filter();
    test_busy_collect();
    test_w1c_race();
    test_reads();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
